qlearn_phase_sequencer: RTL and testbench

Sequences the Q-learning phase units (reward, best-hop and peers) of a node over one round and shares the single data-memory port between them. On `go` it launches each enabled unit in ascending index order: start pulse, wait for `done`, then a one-cycle synchronous reset so the unit's sticky `done` clears. While a unit runs, its address, write data and write enable are routed to memory, and memory read data is broadcast to all units. Sits between the node top level and the phase units, directly in front of the data memory.

---
 rtl/qlearn_pkg.sv | 36 +++
 rtl/qlearn_mem_mux.sv | 34 +++
 rtl/qlearn_phase_sequencer.sv | 133 +++++++++++++
 tb/tb_qlearn_phase_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qlearn_pkg.sv
// Shared definitions for the Q-learning phase sequencer and its memory mux.
package qlearn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_CLEAR,
        S_DONE
    } state_t;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_WORD_W = 16;

    localparam int REWARD  = 0;
    localparam int BESTHOP = 1;

    localparam logic [10:0] REWARD_BASE  = 11'h048;
    localparam logic [10:0] BESTHOP_BASE = 11'h148;
    localparam logic [10:0] PEER_BASE    = 11'h1C8;

    // Lowest set bit of mask at or above 'from'; 8 means none.
    function automatic logic [3:0] next_set(
        input logic [7:0] mask,
        input logic [3:0] from
    );
        logic [3:0] r;
        r = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= from))
                r = 4'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/qlearn_mem_mux.sv
// Selects the owning unit's address, write data and write enable
// onto the shared data-memory port.
module qlearn_mem_mux
    import qlearn_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int WORD_W    = DEF_WORD_W
) (
    input  logic [2:0]                  idx,
    input  logic                        gate,
    input  logic                        we_gate,
    input  logic [NUM_UNITS*ADDR_W-1:0] unit_addr,
    input  logic [NUM_UNITS*WORD_W-1:0] unit_wdata,
    input  logic [NUM_UNITS-1:0]        unit_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [WORD_W-1:0]           mem_wdata,
    output logic                        mem_we
);

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (gate && (idx == 3'(i))) begin
                mem_addr  = unit_addr[i*ADDR_W +: ADDR_W];
                mem_wdata = unit_wdata[i*WORD_W +: WORD_W];
                mem_we    = we_gate & unit_we[i];
            end
        end
    end

endmodule

// File: rtl/qlearn_phase_sequencer.sv
// Runs each enabled phase unit in index order for one round and
// hands the data-memory port to whichever unit is running.
module qlearn_phase_sequencer
    import qlearn_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int WORD_W    = DEF_WORD_W,
    parameter int TIMEOUT   = 1023
) (
    input  logic                        clock,
    input  logic                        rst,
    input  logic                        go,
    input  logic [NUM_UNITS-1:0]        unit_en,
    output logic [NUM_UNITS-1:0]        unit_start,
    output logic [NUM_UNITS-1:0]        unit_nrst,
    input  logic [NUM_UNITS-1:0]        unit_done,
    input  logic [NUM_UNITS*ADDR_W-1:0] unit_addr,
    input  logic [NUM_UNITS*WORD_W-1:0] unit_wdata,
    input  logic [NUM_UNITS-1:0]        unit_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [WORD_W-1:0]           mem_wdata,
    output logic                        mem_we,
    input  logic [WORD_W-1:0]           mem_rdata,
    output logic [WORD_W-1:0]           unit_rdata,
    output logic                        busy,
    output logic [2:0]                  active_idx,
    output logic                        round_done,
    output logic                        timeout_err
);

    state_t               state;
    logic [2:0]           idx;
    logic [NUM_UNITS-1:0] en_q;
    logic [15:0]          cnt;
    logic [3:0]           first;
    logic [3:0]           nxt;
    logic [NUM_UNITS-1:0] idx_oh;
    logic [NUM_UNITS-1:0] first_oh;
    logic [NUM_UNITS-1:0] nxt_oh;

    assign first    = next_set(8'(unit_en), 4'd0);
    assign nxt      = next_set(8'(en_q), {1'b0, idx} + 4'd1);
    assign idx_oh   = NUM_UNITS'(1) << idx;
    assign first_oh = NUM_UNITS'(1) << first[2:0];
    assign nxt_oh   = NUM_UNITS'(1) << nxt[2:0];

    assign busy       = (state != S_IDLE);
    assign active_idx = idx;
    assign unit_rdata = mem_rdata;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            en_q        <= '0;
            cnt         <= '0;
            unit_start  <= '0;
            unit_nrst   <= '0;
            round_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            unit_start <= '0;
            unit_nrst  <= '1;
            round_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (go) begin
                        en_q        <= unit_en;
                        timeout_err <= 1'b0;
                        if (|unit_en) begin
                            idx        <= first[2:0];
                            unit_start <= first_oh;
                            state      <= S_LAUNCH;
                        end else begin
                            round_done <= 1'b1;
                            state      <= S_DONE;
                        end
                    end
                end
                S_LAUNCH: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt + 16'd1;
                    // done wins over a timeout landing in the same cycle
                    if (|(unit_done & idx_oh)) begin
                        unit_nrst <= ~idx_oh;
                        state     <= S_CLEAR;
                    end else if (cnt == 16'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        unit_nrst   <= ~idx_oh;
                        state       <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (!nxt[3]) begin
                        idx        <= nxt[2:0];
                        unit_start <= nxt_oh;
                        state      <= S_LAUNCH;
                    end else begin
                        round_done <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    qlearn_mem_mux #(
        .NUM_UNITS (NUM_UNITS),
        .ADDR_W    (ADDR_W),
        .WORD_W    (WORD_W)
    ) u_mux (
        .idx        (idx),
        .gate       ((state == S_LAUNCH) || (state == S_WAIT)),
        .we_gate    (state == S_WAIT),
        .unit_addr  (unit_addr),
        .unit_wdata (unit_wdata),
        .unit_we    (unit_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we)
    );

endmodule

// File: tb/tb_qlearn_phase_sequencer.sv
// Directed bench for qlearn_phase_sequencer with simple
// latency-programmable phase-unit models.
module tb_qlearn_phase_sequencer;

    localparam int NU = 4;
    localparam int AW = 11;
    localparam int WW = 16;
    localparam int TO = 8;

    logic            clock = 1'b0;
    logic            rst;
    logic            go;
    logic [NU-1:0]   unit_en;
    logic [NU-1:0]   unit_start;
    logic [NU-1:0]   unit_nrst;
    logic [NU-1:0]   unit_done;
    logic [NU*AW-1:0] unit_addr;
    logic [NU*WW-1:0] unit_wdata;
    logic [NU-1:0]   unit_we;
    logic [AW-1:0]   mem_addr;
    logic [WW-1:0]   mem_wdata;
    logic            mem_we;
    logic [WW-1:0]   mem_rdata;
    logic [WW-1:0]   unit_rdata;
    logic            busy;
    logic [2:0]      active_idx;
    logic            round_done;
    logic            timeout_err;

    int checks = 0;
    int failures = 0;
    int g;

    always #5 clock = ~clock;

    qlearn_phase_sequencer #(
        .NUM_UNITS (NU),
        .ADDR_W    (AW),
        .WORD_W    (WW),
        .TIMEOUT   (TO)
    ) dut (
        .clock       (clock),
        .rst         (rst),
        .go          (go),
        .unit_en     (unit_en),
        .unit_start  (unit_start),
        .unit_nrst   (unit_nrst),
        .unit_done   (unit_done),
        .unit_addr   (unit_addr),
        .unit_wdata  (unit_wdata),
        .unit_we     (unit_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata),
        .unit_rdata  (unit_rdata),
        .busy        (busy),
        .active_idx  (active_idx),
        .round_done  (round_done),
        .timeout_err (timeout_err)
    );

    // unit models: done rises lat cycles after start is seen; lat 0 = never
    int lat [NU];
    int mcnt [NU];
    logic [NU-1:0] run;
    logic [NU-1:0] done_r;
    assign unit_done = done_r;

    always @(posedge clock) begin
        for (int i = 0; i < NU; i++) begin
            if (!unit_nrst[i]) begin
                run[i]    <= 1'b0;
                mcnt[i]   <= 0;
                done_r[i] <= 1'b0;
            end else if (unit_start[i]) begin
                run[i]  <= 1'b1;
                mcnt[i] <= 0;
            end else if (run[i] && lat[i] != 0) begin
                mcnt[i] <= mcnt[i] + 1;
                if (mcnt[i] + 1 == lat[i])
                    done_r[i] <= 1'b1;
            end
        end
    end

    int cyc = 0;
    int start_cnt [NU];
    int start_cyc [NU];
    int nrst_cnt [NU];
    int nrst_cyc [NU];
    int rd_cnt, rd_cyc, busy_cnt;
    logic launch_we, clear_we, prev_start, w_we;
    logic [AW-1:0] w_addr, l_addr;
    logic [WW-1:0] w_wdata;
    logic [2:0] w_idx;

    always @(negedge clock) begin
        cyc++;
        if (!rst) begin
            for (int i = 0; i < NU; i++) begin
                if (unit_start[i]) begin
                    start_cnt[i]++;
                    start_cyc[i] = cyc;
                end
                if (!unit_nrst[i]) begin
                    nrst_cnt[i]++;
                    nrst_cyc[i] = cyc;
                end
            end
            if (round_done) begin
                rd_cnt++;
                rd_cyc = cyc;
            end
            if (busy) busy_cnt++;
            if (|unit_start) begin
                launch_we = launch_we | mem_we;
                l_addr = mem_addr;
            end
            if (!(&unit_nrst)) clear_we = clear_we | mem_we;
            if (prev_start) begin
                w_addr  = mem_addr;
                w_wdata = mem_wdata;
                w_we    = mem_we;
                w_idx   = active_idx;
            end
            prev_start = |unit_start;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < NU; i++) begin
            start_cnt[i] = 0;
            start_cyc[i] = 0;
            nrst_cnt[i]  = 0;
            nrst_cyc[i]  = 0;
        end
        rd_cnt = 0;
        rd_cyc = 0;
        busy_cnt = 0;
        launch_we = 1'b0;
        clear_we = 1'b0;
        prev_start = 1'b0;
        w_addr = '0;
        w_wdata = '0;
        w_we = 1'b0;
        w_idx = '0;
        l_addr = '0;
    endtask

    task automatic go_round(input logic [NU-1:0] en);
        unit_en = en;
        go = 1'b1;
        tick();
        go = 1'b0;
        g = cyc;
    endtask

    task automatic wait_round(input int maxc);
        int n;
        n = 0;
        while (rd_cnt == 0 && n < maxc) begin
            tick();
            n++;
        end
        check("round_seen", 32'(rd_cnt != 0), 1);
        tick();
        tick();
    endtask

    initial begin
        rst = 1'b1;
        go = 1'b0;
        unit_en = '0;
        mem_rdata = 16'h5A5A;
        unit_addr  = {11'h148, 11'h1C8, 11'h1CA, 11'h048};
        unit_wdata = {16'h3333, 16'h2222, 16'hBEEF, 16'h1111};
        unit_we = 4'hF;
        for (int i = 0; i < NU; i++) lat[i] = 0;
        clear_stats();

        #12;
        check("rst_start", unit_start, 0);
        check("rst_nrst", unit_nrst, 0);
        check("rst_rdone", round_done, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_busy", busy, 0);
        check("rst_idx", active_idx, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rdata_bcast", unit_rdata, 16'h5A5A);
        tick();
        rst = 1'b0;
        tick();
        check("nrst_release", unit_nrst, 4'hF);
        clear_stats();

        // mask 0101, unit 0 latency 5, unit 2 latency 3
        lat[0] = 5;
        lat[2] = 3;
        go_round(4'b0101);
        wait_round(60);
        check("t1_st0_cnt", start_cnt[0], 1);
        check("t1_st1_cnt", start_cnt[1], 0);
        check("t1_st2_cnt", start_cnt[2], 1);
        check("t1_st3_cnt", start_cnt[3], 0);
        check("t1_nr0_cnt", nrst_cnt[0], 1);
        check("t1_nr2_cnt", nrst_cnt[2], 1);
        check("t1_nr13_cnt", nrst_cnt[1] + nrst_cnt[3], 0);
        check("t1_st0_t", start_cyc[0] - g, 1);
        check("t1_nr0_t", nrst_cyc[0] - g, 8);
        check("t1_st2_t", start_cyc[2] - g, 9);
        check("t1_nr2_t", nrst_cyc[2] - g, 14);
        check("t1_rd_cnt", rd_cnt, 1);
        check("t1_rd_t", rd_cyc - g, 15);
        check("t1_busy_n", busy_cnt, 15);
        check("t1_terr", timeout_err, 0);
        check("t1_launch_we", launch_we, 0);
        check("t1_clear_we", clear_we, 0);

        // unit 1 owns memory
        clear_stats();
        lat[1] = 2;
        go_round(4'b0010);
        wait_round(40);
        check("t2_waddr", w_addr, 11'h1CA);
        check("t2_wdata", w_wdata, 16'hBEEF);
        check("t2_wwe", w_we, 1);
        check("t2_widx", w_idx, 1);
        check("t2_laddr", l_addr, 11'h1CA);
        check("t2_launch_we", launch_we, 0);
        check("t2_clear_we", clear_we, 0);
        check("t2_idle_addr", mem_addr, 0);
        check("t2_idle_wdata", mem_wdata, 0);
        check("t2_idle_we", mem_we, 0);
        check("t2_rd_cnt", rd_cnt, 1);

        // unit 1 never finishes, unit 3 latency 2
        clear_stats();
        lat[1] = 0;
        lat[3] = 2;
        go_round(4'b1010);
        wait_round(60);
        check("t3_st1_t", start_cyc[1] - g, 1);
        check("t3_nr1_t", nrst_cyc[1] - g, 10);
        check("t3_st3_t", start_cyc[3] - g, 11);
        check("t3_nr3_t", nrst_cyc[3] - g, 15);
        check("t3_rd_t", rd_cyc - g, 16);
        check("t3_st3_cnt", start_cnt[3], 1);
        check("t3_terr", timeout_err, 1);

        // empty mask; also clears the sticky timeout flag
        clear_stats();
        go_round(4'b0000);
        check("t4_terr_clr", timeout_err, 0);
        check("t4_busy", busy, 1);
        check("t4_rdone", round_done, 1);
        tick();
        check("t4_busy_off", busy, 0);
        check("t4_rdone_off", round_done, 0);
        tick();
        check("t4_starts", start_cnt[0] + start_cnt[1] + start_cnt[2] + start_cnt[3], 0);
        check("t4_rd_cnt", rd_cnt, 1);
        check("t4_rd_t", rd_cyc - g, 1);
        check("t4_busy_n", busy_cnt, 1);

        // go and mask changes while busy are ignored
        clear_stats();
        lat[0] = 4;
        lat[3] = 2;
        go_round(4'b1001);
        tick();
        tick();
        unit_en = 4'b0110;
        go = 1'b1;
        tick();
        tick();
        tick();
        go = 1'b0;
        wait_round(60);
        tick();
        tick();
        check("t5_st0", start_cnt[0], 1);
        check("t5_st1", start_cnt[1], 0);
        check("t5_st2", start_cnt[2], 0);
        check("t5_st3", start_cnt[3], 1);
        check("t5_nr0_t", nrst_cyc[0] - g, 7);
        check("t5_st3_t", start_cyc[3] - g, 8);
        check("t5_rd_t", rd_cyc - g, 13);
        check("t5_rd_cnt", rd_cnt, 1);
        unit_en = '0;

        // reset during unit 2 WAIT
        clear_stats();
        lat[0] = 2;
        lat[1] = 2;
        lat[2] = 0;
        lat[3] = 0;
        go_round(4'b0111);
        for (int n = 0; n < 40 && start_cnt[2] == 0; n++) tick();
        check("t6_reach_u2", start_cnt[2], 1);
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("t6_busy", busy, 0);
        check("t6_nrst", unit_nrst, 0);
        check("t6_start", unit_start, 0);
        check("t6_we", mem_we, 0);
        check("t6_addr", mem_addr, 0);
        check("t6_idx", active_idx, 0);
        check("t6_rdone", round_done, 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("t6_no_rd", rd_cnt, 0);
        check("t6_idle", busy, 0);
        clear_stats();
        lat[2] = 3;
        go_round(4'b0111);
        wait_round(60);
        check("t6_st_t0", start_cyc[0] - g, 1);
        check("t6_st_t1", start_cyc[1] - g, 6);
        check("t6_st_t2", start_cyc[2] - g, 11);
        check("t6_nr_t2", nrst_cyc[2] - g, 16);
        check("t6_rd_t", rd_cyc - g, 17);
        check("t6_rd_cnt", rd_cnt, 1);
        check("t6_terr", timeout_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
